// File: rtl/keypad_scanner.sv
// Row-scanning keypad engine: dwell timing, press/release debounce and key strobe.
// Define AUTO_REPEAT_EN to add repeat strobes while the accepted key stays held.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned DEBOUNCE_CNT = 8,
  parameter int unsigned NUM_ROWS     = 4,
  parameter int unsigned REPEAT_DLY   = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       press,
  input  logic [3:0] scan_code,
  output logic [2:0] sel,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  localparam int unsigned DW = $clog2(SCAN_DIV);
  localparam int unsigned CW = $clog2(DEBOUNCE_CNT + 1);

  if (SCAN_DIV < 2 || DEBOUNCE_CNT == 0 || NUM_ROWS == 0 || NUM_ROWS > 8 || REPEAT_DLY == 0)
  begin : g_bad_params
    $error("keypad_scanner: illegal parameter value");
  end

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] dwell, dwell_nxt;
  logic [CW-1:0] deb_cnt, deb_cnt_nxt;
  logic [CW-1:0] rel_cnt, rel_cnt_nxt;
  logic [3:0]    cand, cand_nxt;
  logic [2:0]    sel_nxt;
  logic [3:0]    key_code_nxt;
  logic          key_valid_nxt;
  logic          key_down_nxt;
  logic          sample_c;
  logic [2:0]    sel_inc_c;

`ifdef AUTO_REPEAT_EN
  localparam int unsigned RW = $clog2(REPEAT_DLY + 1);
  logic [RW-1:0] rpt_cnt, rpt_cnt_nxt;
`endif

  assign sample_c  = (dwell == DW'(SCAN_DIV - 1));
  assign sel_inc_c = (sel == 3'(NUM_ROWS - 1)) ? 3'd0 : sel + 3'd1;

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SCAN;
      dwell     <= '0;
      deb_cnt   <= '0;
      rel_cnt   <= '0;
      cand      <= 4'hF;
      sel       <= 3'd0;
      key_code  <= 4'hF;
      key_valid <= 1'b0;
      key_down  <= 1'b0;
`ifdef AUTO_REPEAT_EN
      rpt_cnt   <= '0;
`endif
    end else begin
      state     <= state_nxt;
      dwell     <= dwell_nxt;
      deb_cnt   <= deb_cnt_nxt;
      rel_cnt   <= rel_cnt_nxt;
      cand      <= cand_nxt;
      sel       <= sel_nxt;
      key_code  <= key_code_nxt;
      key_valid <= key_valid_nxt;
      key_down  <= key_down_nxt;
`ifdef AUTO_REPEAT_EN
      rpt_cnt   <= rpt_cnt_nxt;
`endif
    end
  end

  // Next-state logic; decoder inputs only matter at the end of each dwell
  always_comb begin
    state_nxt     = state;
    dwell_nxt     = sample_c ? '0 : dwell + DW'(1);
    deb_cnt_nxt   = deb_cnt;
    rel_cnt_nxt   = rel_cnt;
    cand_nxt      = cand;
    sel_nxt       = sel;
    key_code_nxt  = key_code;
    key_valid_nxt = 1'b0;
    key_down_nxt  = key_down;
`ifdef AUTO_REPEAT_EN
    rpt_cnt_nxt   = rpt_cnt;
`endif

    if (sample_c) begin
      case (state)
        SCAN: begin
          if (press) begin
            cand_nxt    = scan_code;
            deb_cnt_nxt = CW'(1);
            if (DEBOUNCE_CNT == 1) begin
              state_nxt     = HELD;
              key_code_nxt  = scan_code;
              key_valid_nxt = 1'b1;
              key_down_nxt  = 1'b1;
              deb_cnt_nxt   = '0;
              rel_cnt_nxt   = '0;
`ifdef AUTO_REPEAT_EN
              rpt_cnt_nxt   = '0;
`endif
            end else begin
              state_nxt = DEBOUNCE;
            end
          end else begin
            sel_nxt = sel_inc_c;
          end
        end

        DEBOUNCE: begin
          if (press && scan_code == cand) begin
            if (deb_cnt + CW'(1) == CW'(DEBOUNCE_CNT)) begin
              state_nxt     = HELD;
              key_code_nxt  = cand;
              key_valid_nxt = 1'b1;
              key_down_nxt  = 1'b1;
              deb_cnt_nxt   = '0;
              rel_cnt_nxt   = '0;
`ifdef AUTO_REPEAT_EN
              rpt_cnt_nxt   = '0;
`endif
            end else begin
              deb_cnt_nxt = deb_cnt + CW'(1);
            end
          end else begin
            state_nxt   = SCAN;
            sel_nxt     = sel_inc_c;
            deb_cnt_nxt = '0;
          end
        end

        HELD: begin
          if (!press) begin
`ifdef AUTO_REPEAT_EN
            rpt_cnt_nxt = '0;
`endif
            if (rel_cnt + CW'(1) == CW'(DEBOUNCE_CNT)) begin
              state_nxt    = SCAN;
              sel_nxt      = sel_inc_c;
              key_down_nxt = 1'b0;
              rel_cnt_nxt  = '0;
              deb_cnt_nxt  = '0;
            end else begin
              rel_cnt_nxt = rel_cnt + CW'(1);
            end
          end else begin
            rel_cnt_nxt = '0;
`ifdef AUTO_REPEAT_EN
            // Repeat only while the same key stays on the frozen row
            if (scan_code == key_code) begin
              if (rpt_cnt + RW'(1) == RW'(REPEAT_DLY)) begin
                key_valid_nxt = 1'b1;
                rpt_cnt_nxt   = '0;
              end else begin
                rpt_cnt_nxt = rpt_cnt + RW'(1);
              end
            end
`else
            key_valid_nxt = 1'b0;
`endif
          end
        end

        default: begin
          state_nxt   = SCAN;
          deb_cnt_nxt = '0;
          rel_cnt_nxt = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a two-key decoder model driven from sel.
module tb_keypad_scanner;

`ifdef AUTO_REPEAT_EN
  localparam bit REPEAT_ON = 1'b1;
`else
  localparam bit REPEAT_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       press;
  logic [3:0] scan_code;
  logic [2:0] sel;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_down;

  logic       a_on = 1'b0, b_on = 1'b0;
  logic [2:0] a_row = 3'd0, b_row = 3'd0;
  logic [3:0] a_code = 4'hF, b_code = 4'hF;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  keypad_scanner #(
    .SCAN_DIV(4), .DEBOUNCE_CNT(3), .NUM_ROWS(4), .REPEAT_DLY(2)
  ) dut (
    .clk(clk), .rst(rst), .press(press), .scan_code(scan_code),
    .sel(sel), .key_code(key_code), .key_valid(key_valid), .key_down(key_down)
  );

  always #5 clk = ~clk;

  // Keypad plus decoder: a key reports only while its row is selected
  always_comb begin
    press     = 1'b0;
    scan_code = 4'hF;
    if (a_on && sel == a_row) begin
      press     = 1'b1;
      scan_code = a_code;
    end else if (b_on && sel == b_row) begin
      press     = 1'b1;
      scan_code = b_code;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic test_reset();
    a_on = 1'b0; b_on = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    total++;
    if (sel !== 3'd0 || key_code !== 4'hF || key_valid !== 1'b0 || key_down !== 1'b0)
      $display("FAIL reset_values got sel=%0d code=%h valid=%b down=%b exp sel=0 code=f valid=0 down=0",
               sel, key_code, key_valid, key_down);
    else passed++;
  endtask

  task automatic test_no_key();
    logic [2:0] es;
    a_on = 1'b0; b_on = 1'b0;
    do_reset();
    for (int c = 0; c < 40; c++) begin
      es = 3'((c / 4) % 4);
      total++;
      if (sel !== es) $display("FAIL nokey_sel cyc=%0d got=%0d exp=%0d", c, sel, es);
      else passed++;
      total++;
      if (key_valid !== 1'b0 || key_code !== 4'hF)
        $display("FAIL nokey_out cyc=%0d got valid=%b code=%h exp valid=0 code=f", c, key_valid, key_code);
      else passed++;
      step();
    end
  endtask

  task automatic test_hold_key5();
    logic [2:0] es;
    logic       ev, ed;
    logic [3:0] ec;
    a_on = 1'b1; a_row = 3'd1; a_code = 4'h5; b_on = 1'b0;
    do_reset();
    for (int c = 0; c < 20; c++) begin
      es = (c < 4) ? 3'd0 : 3'd1;
      ev = (c == 16);
      ed = (c >= 16);
      ec = (c >= 16) ? 4'h5 : 4'hF;
      total++;
      if (sel !== es || key_valid !== ev || key_down !== ed || key_code !== ec)
        $display("FAIL hold5 cyc=%0d got sel=%0d v=%b d=%b code=%h exp sel=%0d v=%b d=%b code=%h",
                 c, sel, key_valid, key_down, key_code, es, ev, ed, ec);
      else passed++;
      step();
    end
  endtask

  task automatic test_release_bounce();
    logic [2:0] es;
    logic       ed;
    for (int c = 20; c < 44; c++) begin
      if (c == 20) a_on = 1'b0;
      if (c == 24) a_on = 1'b1;
      if (c == 28) a_on = 1'b0;
      es = (c < 40) ? 3'd1 : 3'd2;
      ed = (c < 40);
      total++;
      if (cyc !== c || sel !== es || key_down !== ed || key_valid !== 1'b0 || key_code !== 4'h5)
        $display("FAIL release cyc=%0d got sel=%0d v=%b d=%b code=%h exp sel=%0d v=0 d=%b code=5",
                 c, sel, key_valid, key_down, key_code, es, ed);
      else passed++;
      step();
    end
  endtask

  task automatic test_glitch();
    logic [2:0] es;
    a_on = 1'b1; a_row = 3'd1; a_code = 4'h5; b_on = 1'b0;
    do_reset();
    for (int c = 0; c < 20; c++) begin
      if (c == 8) a_on = 1'b0;
      es = (c < 4) ? 3'd0 : (c < 12) ? 3'd1 : (c < 16) ? 3'd2 : 3'd3;
      total++;
      if (sel !== es || key_valid !== 1'b0 || key_down !== 1'b0)
        $display("FAIL glitch cyc=%0d got sel=%0d v=%b d=%b exp sel=%0d v=0 d=0",
                 c, sel, key_valid, key_down, es);
      else passed++;
      step();
    end
  endtask

  task automatic test_multi_key();
    logic [2:0] es;
    logic       ev, ed;
    logic [3:0] ec;
    a_on = 1'b1; a_row = 3'd2; a_code = 4'h9;
    b_on = 1'b1; b_row = 3'd3; b_code = 4'h0;
    do_reset();
    for (int c = 0; c < 52; c++) begin
      if (c == 24) a_on = 1'b0;
      es = (c < 4) ? 3'd0 : (c < 8) ? 3'd1 : (c < 36) ? 3'd2 : 3'd3;
      ev = (c == 20) || (c == 48);
      ed = (c >= 20 && c < 36) || (c >= 48);
      ec = (c < 20) ? 4'hF : (c < 48) ? 4'h9 : 4'h0;
      total++;
      if (sel !== es || key_valid !== ev || key_down !== ed || key_code !== ec)
        $display("FAIL multi cyc=%0d got sel=%0d v=%b d=%b code=%h exp sel=%0d v=%b d=%b code=%h",
                 c, sel, key_valid, key_down, key_code, es, ev, ed, ec);
      else passed++;
      step();
    end
    b_on = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [2:0] es;
    logic       ev, ed;
    logic [3:0] ec;
    a_on = 1'b1; a_row = 3'd2; a_code = 4'h8; b_on = 1'b0;
    do_reset();
    while (cyc < 12) step();
    total++;
    if (sel !== 3'd2 || key_valid !== 1'b0)
      $display("FAIL rstmid_pre got sel=%0d v=%b exp sel=2 v=0", sel, key_valid);
    else passed++;
    rst = 1'b1;
    step();
    total++;
    if (sel !== 3'd0 || key_down !== 1'b0 || key_valid !== 1'b0 || key_code !== 4'hF)
      $display("FAIL rstmid_post got sel=%0d d=%b v=%b code=%h exp sel=0 d=0 v=0 code=f",
               sel, key_down, key_valid, key_code);
    else passed++;
    rst = 1'b0;
    cyc = 0;
    for (int c = 0; c < 24; c++) begin
      es = (c < 4) ? 3'd0 : (c < 8) ? 3'd1 : 3'd2;
      ev = (c == 20);
      ed = (c >= 20);
      ec = (c >= 20) ? 4'h8 : 4'hF;
      total++;
      if (sel !== es || key_valid !== ev || key_down !== ed || key_code !== ec)
        $display("FAIL rstmid_rescan cyc=%0d got sel=%0d v=%b d=%b code=%h exp sel=%0d v=%b d=%b code=%h",
                 c, sel, key_valid, key_down, key_code, es, ev, ed, ec);
      else passed++;
      step();
    end
    a_on = 1'b0;
  endtask

  task automatic test_hold_key3();
    logic ev;
    a_on = 1'b1; a_row = 3'd0; a_code = 4'h3; b_on = 1'b0;
    do_reset();
    for (int c = 0; c < 41; c++) begin
      ev = (c == 12) || (REPEAT_ON && c > 12 && ((c - 12) % 8) == 0);
      total++;
      if (sel !== 3'd0 || key_valid !== ev || key_down !== (c >= 12) ||
          key_code !== ((c >= 12) ? 4'h3 : 4'hF))
        $display("FAIL hold3 cyc=%0d got sel=%0d v=%b d=%b code=%h exp sel=0 v=%b d=%b",
                 c, sel, key_valid, key_down, key_code, ev, (c >= 12));
      else passed++;
      step();
    end
    a_on = 1'b0;
  endtask

  initial begin
    test_reset();
    test_no_key();
    test_hold_key5();
    test_release_bounce();
    test_glitch();
    test_multi_key();
    test_reset_mid();
    test_hold_key3();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
